uart_tx_arb: RTL and testbench
==============================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter: DATA_BITS, 8, payload bits per frame; only the value 8 is supported.
REQ-002 Parameter: CNT_W, 32, width of the baud configuration and the bit-period counter.
REQ-003 Port: uart_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: cfg_baud  input  CNT_W  uart_clk cycles per UART bit period.
REQ-006 Port: cfg_stop2  input  1  selects stop bits per frame: 1 = two, 0 = one.
REQ-007 Port: req0_valid / req0_data / req0_ready  input / input / output  1 / 8 / 1  requester 0 byte handshake.
REQ-008 Port: req1_valid / req1_data / req1_ready  input / input / output  1 / 8 / 1  requester 1 byte handshake.
REQ-009 Port: tx  output  1  serial line; idle level high.
REQ-010 Port: busy  output  1  high whenever the FSM is not IDLE.
REQ-011 Port: grant_id  output  1  index of the requester whose byte is in flight; holds its last value while idle.

Function
REQ-012 Effective period P SHALL be cfg_baud, except that cfg_baud values 0 and 1 SHALL both give P = 1.
REQ-013 P and cfg_stop2 SHALL be sampled only on a handshake cycle; changes mid-frame SHALL NOT affect the frame in flight.
REQ-014 The FSM SHALL have four states: IDLE, START, DATA, STOP.
REQ-015 Transfers: IDLE -> START on handshake; START -> DATA after P cycles; DATA -> STOP after 8*P cycles; STOP -> IDLE after P cycles, or 2*P cycles when stop2 was latched.
REQ-016 reqN_ready SHALL be combinational and asserted only in IDLE, only for the requester selected by arbitration.
REQ-017 A handshake is reqN_valid && reqN_ready; the data is latched in that cycle.
REQ-018 Arbitration SHALL be round-robin:
- a single valid requester wins;
- when both are valid, the requester not granted most recently wins;
- the pointer resets to favour requester 0.
REQ-019 After a handshake in cycle T:
- tx = 0 in cycles T+1 .. T+P;
- data bit i (LSB first) in cycles T+1+(1+i)P .. T+(2+i)P;
- tx = 1 for the stop bits;
- IDLE is re-entered at cycle T+1+10P (one stop bit) or T+1+11P (two stop bits).
REQ-020 A new handshake SHALL be accepted in the first IDLE cycle, giving exactly one extra high cycle between back-to-back frames.
REQ-021 The bit-period counter SHALL count 0..P-1, restart at 0 on every state transition and never wrap mid-bit; its width SHALL be CNT_W.
REQ-022 tx SHALL be driven from a register (glitch-free).
REQ-023 busy SHALL assert in the cycle after the handshake and deassert on return to IDLE.
REQ-024 A valid deasserted without a handshake SHALL leave the arbitration pointer unchanged.

Reset
REQ-025 While rst is high, the next edge SHALL force:
- FSM = IDLE, tx = 1, busy = 0, grant_id = 0;
- counter = 0, RR pointer favouring requester 0;
- both ready outputs = 0 during the reset cycle.
REQ-026 Reset asserted mid-frame SHALL abort the frame; tx SHALL be 1 from the next cycle and no byte SHALL be retransmitted.

Structure
REQ-027 Package uart_pkg SHALL hold:
- the FSM state enum;
- the DATA_BITS constant;
- the start, idle and stop line-level constants.
REQ-028 One sub-module, uart_baud_cnt, SHALL implement the bit-period counter.
- Inputs: uart_clk, rst, restart, period.
- Output: bit_done, high on count P-1.
REQ-029 Arbiter, FSM and shift register SHALL reside in uart_tx_arb.

Verification
REQ-030 Single byte: cfg_baud=4, req0 sends 0xA5 -> tx pattern (4 cycles each) 0,1,0,1,0,0,1,0,1,1; busy high for 40 cycles.
REQ-031 Contention: cfg_baud=2, both valid continuously with 0x11 / 0x22 -> grants alternate 0,1,0,1; the first frame carries 0x11.
REQ-032 Config stability: cfg_baud changed from 4 to 8 mid-frame -> the current frame keeps 4-cycle bits; the next frame uses 8.
REQ-033 Reset mid-frame: rst pulsed during DATA bit 3 -> tx = 1 and busy = 0 from the next cycle; the next handshake is served by requester 0 when both are valid.
REQ-034 Edge period: cfg_baud=0, cfg_stop2=1, byte 0xFF -> 11-cycle frame, tx = 0 for exactly 1 cycle, re-enter IDLE at T+12.
REQ-035 Back-to-back: req1 held valid for 3 bytes at cfg_baud=3 -> handshakes exactly 31 cycles apart.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the arbitrated UART transmitter:
//   - DATA_BITS   : payload bits per frame
//   - LINE_*      : serial line levels for idle, start and stop
//   - tx_state_e  : transmitter FSM state encoding
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

endpackage : uart_pkg

// File: rtl/uart_baud_cnt.sv
// -----------------------------------------------------------------------------
// uart_baud_cnt
// Bit-period counter. Counts 0..period-1 and flags the last cycle of each
// bit period; wraps to 0 after that cycle or whenever restart is high.
// Ports:
//   uart_clk  in   clock
//   rst       in   synchronous active-high reset
//   restart   in   force the count back to 0 on the next edge
//   period    in   bit period in clock cycles (always >= 1)
//   bit_done  out  high while the count equals period-1
// -----------------------------------------------------------------------------
module uart_baud_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             uart_clk,
  input  logic             rst,
  input  logic             restart,
  input  logic [CNT_W-1:0] period,
  output logic             bit_done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign bit_done = (cnt_q == period - CNT_W'(1));

  // NOTE: every variable written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (restart || bit_done) begin
      cnt_d = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of process ordering.
  always_ff @(posedge uart_clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : uart_baud_cnt

// File: rtl/uart_tx_arb.sv
// -----------------------------------------------------------------------------
// uart_tx_arb
// Two-requester UART transmitter: a round-robin arbiter picks one byte while
// idle, then the FSM sends start bit, 8 data bits LSB first, and one or two
// stop bits. Bit period and stop-bit count are captured at the handshake.
// Ports:
//   uart_clk          in   clock
//   rst               in   synchronous active-high reset
//   cfg_baud          in   clock cycles per bit (0 and 1 both mean 1)
//   cfg_stop2         in   1 = two stop bits, 0 = one
//   reqN_valid/data   in   requester N byte offer
//   reqN_ready        out  requester N accepted (combinational, IDLE only)
//   tx                out  registered serial line, idle high
//   busy              out  frame in flight
//   grant_id          out  requester of the current / last frame
// -----------------------------------------------------------------------------
module uart_tx_arb #(
  parameter int unsigned DATA_BITS = uart_pkg::DATA_BITS,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                 uart_clk,
  input  logic                 rst,
  input  logic [CNT_W-1:0]     cfg_baud,
  input  logic                 cfg_stop2,
  input  logic                 req0_valid,
  input  logic [DATA_BITS-1:0] req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [DATA_BITS-1:0] req1_data,
  output logic                 req1_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 grant_id
);

  import uart_pkg::tx_state_e;
  import uart_pkg::ST_IDLE;
  import uart_pkg::ST_START;
  import uart_pkg::ST_DATA;
  import uart_pkg::ST_STOP;
  import uart_pkg::LINE_IDLE;
  import uart_pkg::LINE_START;
  import uart_pkg::LINE_STOP;

  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  tx_state_e            state_q, state_d;
  logic                 tx_q, tx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 stop2_q, stop2_d;
  logic [CNT_W-1:0]     period_q, period_d;
  logic                 grant_q, grant_d;
  logic                 rr_q, rr_d;     // requester favoured on contention

  logic             sel;
  logic             can_accept;
  logic             hs;
  logic             bit_done;
  logic             cnt_restart;
  logic [CNT_W-1:0] period_eff;

  // Arbitration: a lone requester wins, on contention the round-robin pointer
  // decides. The pointer only moves on an actual handshake.
  assign sel        = (req0_valid && req1_valid) ? rr_q : req1_valid;
  assign can_accept = (state_q == ST_IDLE) && !rst;
  assign req0_ready = can_accept && req0_valid && !sel;
  assign req1_ready = can_accept && req1_valid &&  sel;
  assign hs         = can_accept && (req0_valid || req1_valid);

  assign period_eff = (cfg_baud < CNT_W'(2)) ? CNT_W'(1) : cfg_baud;

  assign tx       = tx_q;
  assign busy     = (state_q != ST_IDLE);
  assign grant_id = grant_q;

  // Counter is held at 0 while idle and cleared on every state change so each
  // bit starts with a full period.
  assign cnt_restart = (state_q == ST_IDLE) || (state_d != state_q);

  uart_baud_cnt #(
    .CNT_W (CNT_W)
  ) u_baud_cnt (
    .uart_clk (uart_clk),
    .rst      (rst),
    .restart  (cnt_restart),
    .period   (period_q),
    .bit_done (bit_done)
  );

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    stop2_d    = stop2_q;
    period_d   = period_q;
    grant_d    = grant_q;
    rr_d       = rr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (hs) begin
          state_d    = ST_START;
          tx_d       = LINE_START;
          shift_d    = sel ? req1_data : req0_data;
          period_d   = period_eff;
          stop2_d    = cfg_stop2;
          grant_d    = sel;
          rr_d       = !sel;
          bit_idx_d  = '0;
          stop_idx_d = 1'b0;
        end
      end
      ST_START: begin
        if (bit_done) begin
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
            state_d = ST_STOP;
            tx_d    = LINE_STOP;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          if (stop2_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            tx_d    = LINE_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = LINE_IDLE;
      end
    endcase
  end

  always_ff @(posedge uart_clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tx_q       <= LINE_IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      stop2_q    <= 1'b0;
      period_q   <= CNT_W'(1);
      grant_q    <= 1'b0;
      rr_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      stop2_q    <= stop2_d;
      period_q   <= period_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
    end
  end

endmodule : uart_tx_arb

// File: tb/tb_uart_tx_arb.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arb
// Self-checking bench for uart_tx_arb. A frame-level model predicts tx, busy,
// grant_id and both ready outputs on every cycle; directed scenarios add
// hand-computed literal expectations on the logged waveform and handshakes.
// -----------------------------------------------------------------------------
module tb_uart_tx_arb;

  localparam int CNT_W = 32;
  localparam int LOG_N = 4096;

  logic             uart_clk;
  logic             rst;
  logic [CNT_W-1:0] cfg_baud;
  logic             cfg_stop2;
  logic             req0_valid, req1_valid;
  logic [7:0]       req0_data, req1_data;
  logic             req0_ready, req1_ready;
  logic             tx, busy, grant_id;

  uart_tx_arb #(
    .DATA_BITS (8),
    .CNT_W     (CNT_W)
  ) dut (
    .uart_clk   (uart_clk),
    .rst        (rst),
    .cfg_baud   (cfg_baud),
    .cfg_stop2  (cfg_stop2),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .tx         (tx),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  initial uart_clk = 1'b0;
  always #5 uart_clk = ~uart_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Frame-level model and per-cycle compare. Cycle c is the interval between
  // posedge c and posedge c+1; outputs are sampled at its negedge.
  // ---------------------------------------------------------------------------
  int         cyc = 0;
  int         hs_count = 0;
  int         hs_cyc[$];
  bit         hs_gid[$];
  logic [7:0] hs_data[$];
  logic       line_log [LOG_N];
  logic       busy_log [LOG_N];

  bit         m_active = 1'b0;
  int         m_t = 0, m_p = 1, m_end = 0;
  logic [7:0] m_data = '0;
  bit         m_gid = 1'b0;
  bit         m_ptr = 1'b0;

  always @(negedge uart_clk) begin : compare
    bit   in_frame, w;
    logic e_tx;
    int   b;
    in_frame = m_active && (cyc > m_t) && (cyc < m_end);
    e_tx = 1'b1;
    if (in_frame) begin
      b = (cyc - m_t - 1) / m_p;
      if (b == 0)      e_tx = 1'b0;
      else if (b <= 8) e_tx = m_data[b-1];
    end
    w = (req0_valid && req1_valid) ? m_ptr : req1_valid;

    if (cyc < LOG_N) begin
      line_log[cyc] = tx;
      busy_log[cyc] = busy;
    end

    check($sformatf("tx@%0d", cyc), tx, e_tx);
    check($sformatf("busy@%0d", cyc), busy, in_frame);
    check($sformatf("grant_id@%0d", cyc), grant_id, m_gid);
    check($sformatf("req0_ready@%0d", cyc), req0_ready, !in_frame && !rst && req0_valid && !w);
    check($sformatf("req1_ready@%0d", cyc), req1_ready, !in_frame && !rst && req1_valid && w);

    if (rst) begin
      m_active = 1'b0;
      m_gid    = 1'b0;
      m_ptr    = 1'b0;
    end else if (!in_frame && (req0_valid || req1_valid)) begin
      m_active = 1'b1;
      m_t      = cyc;
      m_p      = (cfg_baud < 2) ? 1 : int'(cfg_baud);
      m_end    = m_t + 1 + 10 * m_p + (cfg_stop2 ? m_p : 0);
      m_data   = w ? req1_data : req0_data;
      m_gid    = w;
      m_ptr    = !w;
      hs_cyc.push_back(cyc);
      hs_gid.push_back(w);
      hs_data.push_back(m_data);
      hs_count++;
    end
    cyc++;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge uart_clk);
      #1;
    end
  endtask

  task automatic wait_hs(input int target, input string name);
    int k = 0;
    while (hs_count < target && k < 2000) begin
      tick(1);
      k++;
    end
    check({"handshake_", name}, hs_count >= target, 1);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy && k < 3000) begin
      tick(1);
      k++;
    end
    check({"idle_", name}, busy, 0);
    tick(2);
  endtask

  function automatic int busy_run(input int t);
    int n = 0;
    while ((t + 1 + n) < LOG_N && busy_log[t+1+n] === 1'b1) n++;
    return n;
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [9:0] pat;
    bit   [3:0] rr_exp;
    int base, t0, t1, t2, t3, k;

    rst        = 1'b1;
    cfg_baud   = 32'd4;
    cfg_stop2  = 1'b0;
    req0_valid = 1'b1;   // ready must stay low during reset even with valid
    req1_valid = 1'b0;
    req0_data  = 8'h00;
    req1_data  = 8'h00;

    // Reset state
    tick(3);
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_grant", grant_id, 0);
    check("reset_ready0", req0_ready, 0);
    req0_valid = 1'b0;
    rst        = 1'b0;
    tick(2);

    // Single byte 0xA5 at P=4
    pat       = 10'b1101001010;
    req0_data = 8'hA5;
    req0_valid = 1'b1;
    base = hs_count;
    wait_hs(base + 1, "single");
    req0_valid = 1'b0;
    wait_idle("single");
    t0 = hs_cyc[base];
    check("single_data", hs_data[base], 8'hA5);
    for (int j = 0; j < 40; j++)
      check($sformatf("single_line_%0d", j), line_log[t0+1+j], pat[j/4]);
    check("single_busy_len", busy_run(t0), 40);
    check("single_idle_at_T41", busy_log[t0+41], 0);

    // Contention at P=2 after reset: grants alternate starting with 0
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    cfg_baud   = 32'd2;
    req0_data  = 8'h11;
    req1_data  = 8'h22;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    base = hs_count;
    wait_hs(base + 4, "contention");
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle("contention");
    rr_exp = 4'b1010;    // gid of handshake i is rr_exp[i]
    for (int i = 0; i < 4; i++)
      check($sformatf("contention_gid_%0d", i), hs_gid[base+i], rr_exp[i]);
    check("contention_first_data", hs_data[base], 8'h11);
    check("contention_second_data", hs_data[base+1], 8'h22);
    check("contention_gap", hs_cyc[base+1] - hs_cyc[base], 21);

    // Config change mid-frame affects only the next frame
    cfg_baud   = 32'd4;
    req0_data  = 8'h3C;
    req0_valid = 1'b1;
    base = hs_count;
    wait_hs(base + 1, "cfg_first");
    t1 = hs_cyc[base];
    req0_data = 8'hC3;
    tick(9);
    cfg_baud = 32'd8;
    wait_hs(base + 2, "cfg_second");
    req0_valid = 1'b0;
    wait_idle("cfg");
    check("cfg_gap", hs_cyc[base+1] - t1, 41);
    check("cfg_first_len", busy_run(t1), 40);
    check("cfg_second_len", busy_run(hs_cyc[base+1]), 80);

    // Reset during data bit 3 (byte 0x52, bit 3 = 0) at P=4
    cfg_baud   = 32'd4;
    req0_data  = 8'h52;
    req0_valid = 1'b1;
    base = hs_count;
    wait_hs(base + 1, "abort");
    req0_valid = 1'b0;
    t2 = hs_cyc[base];
    k = 0;
    while (cyc < t2 + 18 && k < 100) begin
      tick(1);
      k++;
    end
    check("abort_reach_bit3", cyc, t2 + 18);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(6);
    check("abort_line_bit3", line_log[t2+18], 0);
    for (int j = 19; j < 24; j++) begin
      check($sformatf("abort_tx_T%0d", j), line_log[t2+j], 1);
      check($sformatf("abort_busy_T%0d", j), busy_log[t2+j], 0);
    end
    req0_data  = 8'h66;
    req1_data  = 8'h77;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    base = hs_count;
    wait_hs(base + 1, "after_abort");
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle("after_abort");
    check("after_abort_gid", hs_gid[base], 0);
    check("after_abort_data", hs_data[base], 8'h66);

    // Edge period: cfg_baud 0, two stop bits, 0xFF
    cfg_baud   = 32'd0;
    cfg_stop2  = 1'b1;
    req0_data  = 8'hFF;
    req0_valid = 1'b1;
    base = hs_count;
    wait_hs(base + 1, "edge0");
    req0_valid = 1'b0;
    wait_idle("edge0");
    t3 = hs_cyc[base];
    check("edge0_start_low", line_log[t3+1], 0);
    check("edge0_after_start", line_log[t3+2], 1);
    check("edge0_len", busy_run(t3), 11);
    check("edge0_idle_T12", busy_log[t3+12], 0);

    // cfg_baud 1 behaves as P=1 too, one stop bit
    cfg_baud   = 32'd1;
    cfg_stop2  = 1'b0;
    req1_data  = 8'h0F;
    req1_valid = 1'b1;
    base = hs_count;
    wait_hs(base + 1, "edge1");
    req1_valid = 1'b0;
    wait_idle("edge1");
    check("edge1_len", busy_run(hs_cyc[base]), 10);
    check("edge1_gid", hs_gid[base], 1);

    // Back-to-back from requester 1 at P=3
    cfg_baud   = 32'd3;
    req1_data  = 8'h81;
    req1_valid = 1'b1;
    base = hs_count;
    wait_hs(base + 1, "b2b_0");
    req1_data = 8'h42;
    wait_hs(base + 2, "b2b_1");
    req1_data = 8'hC3;
    wait_hs(base + 3, "b2b_2");
    req1_valid = 1'b0;
    wait_idle("b2b");
    check("b2b_gap_01", hs_cyc[base+1] - hs_cyc[base], 31);
    check("b2b_gap_12", hs_cyc[base+2] - hs_cyc[base+1], 31);
    check("b2b_data_0", hs_data[base], 8'h81);
    check("b2b_data_1", hs_data[base+1], 8'h42);
    check("b2b_data_2", hs_data[base+2], 8'hC3);
    for (int i = 0; i < 3; i++)
      check($sformatf("b2b_gid_%0d", i), hs_gid[base+i], 1);

    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_uart_tx_arb
